// File: rtl/omsp_spm_slot_ctrl.sv
// omsp_spm_slot_ctrl
// Sancus protected-module slot controller. Accepts create, destroy-by-id and
// destroy-current requests over a valid/ready handshake, finds the target
// slot in an external array of NB_SLOTS slots, runs the overlap check for
// creates, pulses the slot update and returns status plus module ID.
// Also owns module-ID allocation (next_id / exhausted) and prev_pc tracking.
//
// Ports:
//   mclk, puc_rst_n          clock, async active-low reset
//   pc, pc_en, prev_pc       fetch address in, previous-instruction pc out
//   req_valid/ready/op/id    request channel (op 00 create, 01 destroy-by-id,
//                            10 destroy-current, 11 reserved)
//   rsp_valid/ready/status/id  response channel (00 OK, 01 FULL,
//                            10 EXHAUSTED, 11 REJECT)
//   slot_enabled/id/pc_hit/overlap/violation   per-slot status from the array
//   slot_check, slot_update, slot_enable, assign_id   per-slot control out
//   violation                OR of slot_violation and exhausted
//
// Build option: OMSP_SPM_FAST_SCAN_EN resolves the target slot in a single
// SCAN cycle with a priority encoder instead of walking one slot per cycle.
//
// state    | meaning
// ---------+---------------------------------------------------------
// S_IDLE   | ready for a request
// S_SCAN   | looking for a free slot (create) or matching ID (destroy)
// S_CHECK  | slot_check driven, waiting on slot_overlap
// S_COMMIT | slot_update pulse, ID bookkeeping
// S_RESP   | response held until rsp_ready
module omsp_spm_slot_ctrl #(
  parameter int NB_SLOTS = 4,
  parameter int ID_WIDTH = 16,
  parameter int PC_WIDTH = 16
) (
  input  logic                         mclk,
  input  logic                         puc_rst_n,
  input  logic [PC_WIDTH-1:0]          pc,
  input  logic                         pc_en,
  input  logic                         req_valid,
  input  logic [1:0]                   req_op,
  input  logic [ID_WIDTH-1:0]          req_id,
  output logic                         req_ready,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic [1:0]                   rsp_status,
  output logic [ID_WIDTH-1:0]          rsp_id,
  input  logic [NB_SLOTS-1:0]          slot_enabled,
  input  logic [NB_SLOTS*ID_WIDTH-1:0] slot_id,
  input  logic [NB_SLOTS-1:0]          slot_pc_hit,
  input  logic [NB_SLOTS-1:0]          slot_overlap,
  input  logic [NB_SLOTS-1:0]          slot_violation,
  output logic [NB_SLOTS-1:0]          slot_check,
  output logic [NB_SLOTS-1:0]          slot_update,
  output logic                         slot_enable,
  output logic [ID_WIDTH-1:0]          assign_id,
  output logic [PC_WIDTH-1:0]          prev_pc,
  output logic                         violation
);

  localparam int IW = (NB_SLOTS > 1) ? $clog2(NB_SLOTS) : 1;

  localparam logic [1:0] OP_CREATE   = 2'b00;
  localparam logic [1:0] OP_DEST_ID  = 2'b01;
  localparam logic [1:0] OP_DEST_CUR = 2'b10;

  localparam logic [1:0] ST_OK  = 2'b00;
  localparam logic [1:0] ST_FULL = 2'b01;
  localparam logic [1:0] ST_EXH = 2'b10;
  localparam logic [1:0] ST_REJ = 2'b11;

  typedef enum logic [2:0] {S_IDLE, S_SCAN, S_CHECK, S_COMMIT, S_RESP} state_t;

  state_t              state;
  logic [1:0]          op_q;
  logic [ID_WIDTH-1:0] id_q;
  logic [ID_WIDTH-1:0] next_id;
  logic                exhausted;
  logic [IW-1:0]       target;
  logic [PC_WIDTH-1:0] cur_pc;

  logic [ID_WIDTH-1:0] ids [NB_SLOTS];
  logic [NB_SLOTS-1:0] id_match;
  logic [NB_SLOTS-1:0] scan_vec;
  logic [NB_SLOTS-1:0] cur_vec;
  logic [ID_WIDTH-1:0] id_inc;
  logic                scan_hit;
  logic                scan_last;
  logic [IW-1:0]       scan_tgt;

  function automatic logic [IW-1:0] lowest_set(input logic [NB_SLOTS-1:0] v);
    lowest_set = '0;
    for (int i = NB_SLOTS - 1; i >= 0; i--)
      if (v[i]) lowest_set = IW'(i);
  endfunction

  function automatic logic [NB_SLOTS-1:0] onehot(input logic [IW-1:0] i);
    onehot = NB_SLOTS'(1) << i;
  endfunction

  for (genvar k = 0; k < NB_SLOTS; k++) begin : g_slot
    assign ids[k]      = slot_id[k*ID_WIDTH +: ID_WIDTH];
    assign id_match[k] = slot_enabled[k] && (ids[k] == id_q);
  end

  // Candidate slots: free ones for create, enabled ones with the wanted ID otherwise.
  assign scan_vec = (op_q == OP_CREATE) ? ~slot_enabled : id_match;
  assign cur_vec  = slot_pc_hit & slot_enabled;
  assign id_inc   = next_id + ID_WIDTH'(1);

`ifdef OMSP_SPM_FAST_SCAN_EN
  assign scan_hit  = |scan_vec;
  assign scan_tgt  = lowest_set(scan_vec);
  assign scan_last = 1'b1;
`else
  logic [IW-1:0] scan_idx;
  assign scan_hit  = scan_vec[scan_idx];
  assign scan_tgt  = scan_idx;
  assign scan_last = (scan_idx == IW'(NB_SLOTS - 1));
`endif

  assign req_ready = (state == S_IDLE);
  assign assign_id = next_id;
  assign violation = (|slot_violation) | exhausted;

  always_ff @(posedge mclk or negedge puc_rst_n) begin
    if (!puc_rst_n) begin
      cur_pc  <= '0;
      prev_pc <= '0;
    end else if (pc_en) begin
      prev_pc <= cur_pc;
      cur_pc  <= pc;
    end
  end

  always_ff @(posedge mclk or negedge puc_rst_n) begin
    if (!puc_rst_n) begin
      state       <= S_IDLE;
      op_q        <= OP_CREATE;
      id_q        <= '0;
      next_id     <= ID_WIDTH'(1);
      exhausted   <= 1'b0;
      target      <= '0;
`ifndef OMSP_SPM_FAST_SCAN_EN
      scan_idx    <= '0;
`endif
      rsp_valid   <= 1'b0;
      rsp_status  <= ST_OK;
      rsp_id      <= '0;
      slot_check  <= '0;
      slot_update <= '0;
      slot_enable <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            op_q   <= req_op;
            id_q   <= req_id;
            rsp_id <= '0;
            case (req_op)
              OP_CREATE, OP_DEST_ID: begin
                if (req_op == OP_CREATE && exhausted) begin
                  rsp_valid  <= 1'b1;
                  rsp_status <= ST_EXH;
                  state      <= S_RESP;
                end else begin
`ifndef OMSP_SPM_FAST_SCAN_EN
                  scan_idx <= '0;
`endif
                  state    <= S_SCAN;
                end
              end
              OP_DEST_CUR: begin
                if (|cur_vec) begin
                  target      <= lowest_set(cur_vec);
                  slot_update <= onehot(lowest_set(cur_vec));
                  slot_enable <= 1'b0;
                  state       <= S_COMMIT;
                end else begin
                  rsp_valid  <= 1'b1;
                  rsp_status <= ST_REJ;
                  state      <= S_RESP;
                end
              end
              default: begin
                rsp_valid  <= 1'b1;
                rsp_status <= ST_REJ;
                state      <= S_RESP;
              end
            endcase
          end
        end
        S_SCAN: begin
          if (scan_hit) begin
            target <= scan_tgt;
            if (op_q == OP_CREATE) begin
              slot_check <= slot_enabled & ~onehot(scan_tgt);
              state      <= S_CHECK;
            end else begin
              slot_update <= onehot(scan_tgt);
              slot_enable <= 1'b0;
              state       <= S_COMMIT;
            end
          end else if (scan_last) begin
            rsp_valid  <= 1'b1;
            rsp_status <= (op_q == OP_CREATE) ? ST_FULL : ST_REJ;
            state      <= S_RESP;
          end
`ifndef OMSP_SPM_FAST_SCAN_EN
          else begin
            scan_idx <= scan_idx + IW'(1);
          end
`endif
        end
        S_CHECK: begin
          slot_check <= '0;
          // Overlap is only meaningful for slots being strobed.
          if (|(slot_overlap & slot_check)) begin
            rsp_valid  <= 1'b1;
            rsp_status <= ST_REJ;
            state      <= S_RESP;
          end else begin
            slot_update <= onehot(target);
            slot_enable <= 1'b1;
            state       <= S_COMMIT;
          end
        end
        S_COMMIT: begin
          slot_update <= '0;
          slot_enable <= 1'b0;
          rsp_valid   <= 1'b1;
          rsp_status  <= ST_OK;
          state       <= S_RESP;
          if (op_q == OP_CREATE) begin
            rsp_id  <= next_id;
            next_id <= id_inc;
            if (id_inc == '0) exhausted <= 1'b1;
          end else begin
            rsp_id <= ids[target];
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/omsp_spm_slot_ctrl.md
Name: omsp_spm_slot_ctrl

Overview:
Parametrised successor of the Sancus protected-module controller. It serves create, destroy-by-id and destroy-current requests through a valid/ready request and response handshake. A multi-cycle FSM scans for a slot, runs the overlap check, pulses the slot update and reports the result. It sits between the execution unit's Sancus instruction decode and an external array of NB_SLOTS omsp_spm-style slots, and owns module-ID allocation and prev_pc tracking.

Parameters:
NB_SLOTS, 4, number of protected-module slots (1..32).
ID_WIDTH, 16, width of module IDs and of the ID counter.
PC_WIDTH, 16, width of pc and prev_pc.

Ports:
mclk  in  1  core clock.
puc_rst_n  in  1  reset, asynchronous, active-low.
pc  in  PC_WIDTH  current fetch address.
pc_en  in  1  pc is valid for a new instruction this cycle.
req_valid  in  1  request present.
req_op  in  2  request type: 00 create, 01 destroy-by-id, 10 destroy-current, 11 reserved.
req_id  in  ID_WIDTH  target ID for destroy-by-id.
req_ready  out  1  controller can accept a request.
rsp_valid  out  1  response present.
rsp_ready  in  1  consumer accepts the response.
rsp_status  out  2  result: 00 OK, 01 FULL, 10 EXHAUSTED, 11 REJECT.
rsp_id  out  ID_WIDTH  ID created or destroyed; 0 on any error.
slot_enabled  in  NB_SLOTS  per-slot enabled flags.
slot_id  in  NB_SLOTS*ID_WIDTH  per-slot IDs; slot k occupies bits [k*ID_WIDTH +: ID_WIDTH].
slot_pc_hit  in  NB_SLOTS  pc lies inside slot k's text section.
slot_overlap  in  NB_SLOTS  combinational overlap result while slot_check[k] is high.
slot_violation  in  NB_SLOTS  per-slot access violations.
slot_check  out  NB_SLOTS  overlap-check strobe.
slot_update  out  NB_SLOTS  one-cycle update strobe.
slot_enable  out  1  qualifies slot_update: 1 = create, 0 = destroy.
assign_id  out  ID_WIDTH  ID to load into the created slot; equals next_id.
prev_pc  out  PC_WIDTH  pc of the previous instruction.
violation  out  1  OR of slot_violation, OR'd with exhausted.

Behaviour:
- Reset values: FSM=IDLE; next_id=1; exhausted=0; scan_idx=0; cur_pc=0; prev_pc=0. Outputs: rsp_valid=0, rsp_status=00, rsp_id=0, slot_check=0, slot_update=0, slot_enable=0. req_ready=1 after reset.
- pc tracking: on pc_en, prev_pc<=cur_pc and cur_pc<=pc, both registered. prev_pc holds value when pc_en=0.
- req_ready=1 only in IDLE. A request is accepted on a cycle with req_valid&req_ready. req_op, req_id and target are latched at accept.
- IDLE, on accept:
  - reserved op -> RESP with REJECT.
  - create with exhausted=1 -> RESP with EXHAUSTED.
  - create or destroy-by-id -> SCAN, scan_idx=0.
  - destroy-current: if no bit of slot_pc_hit&slot_enabled is set -> RESP with REJECT; else latch the lowest set bit as target -> COMMIT.
- SCAN: examines slot scan_idx, one slot per cycle.
  - create hit: !slot_enabled[idx] -> target=idx, go to CHECK.
  - destroy-by-id hit: slot_enabled[idx] && slot_id[idx]==req_id -> target=idx, go to COMMIT.
  - No hit at idx=NB_SLOTS-1 -> RESP with FULL (create) or REJECT (destroy-by-id).
  - Worst case NB_SLOTS cycles.
- CHECK (1 cycle): slot_check = slot_enabled & ~onehot(target). Any slot_overlap set -> RESP with REJECT, no update. Otherwise -> COMMIT.
- COMMIT (1 cycle): slot_update=onehot(target).
  - Create: slot_enable=1, assign_id=next_id; next_id increments at the end of the cycle; rsp_id=next_id before the increment.
  - If the increment wraps to 0: exhausted<=1, sticky until reset.
  - Destroy: slot_enable=0; rsp_id=slot_id[target], sampled this cycle.
  - Then -> RESP with OK.
- RESP: rsp_valid=1 with rsp_status and rsp_id held stable. On rsp_ready -> IDLE; rsp_valid drops the next cycle. A new request can be accepted the cycle after returning to IDLE.
- Create latency, free slot k: accept at T; slot_update pulse at T+k+3; rsp_valid from T+k+4.
- slot_update and slot_check are never asserted outside COMMIT and CHECK respectively.
- Reset asserted mid-operation: immediate return to reset values; no partial slot_update.
- slot_violation is combinational into violation; no latching.

Optional Feature:
OMSP_SPM_FAST_SCAN_EN.
- Defined: SCAN lasts exactly 1 cycle. The target is resolved with a combinational priority encoder: first disabled slot for create, lowest matching ID for destroy-by-id. Create latency becomes T+3 for the slot_update pulse and T+4 for rsp_valid, independent of k.
- Undefined: sequential scan as described above. All statuses, next_id behaviour and exhausted behaviour are identical in both builds.

Test Plan:
1. Reset, NB_SLOTS=4, slot_enabled=0011, no overlap, create accepted at T -> slot_update=0100 with slot_enable=1 and assign_id=1 at T+5; rsp_valid at T+6 with OK, rsp_id=1; next_id becomes 2.
2. slot_enabled=1111, create -> no slot_update, FULL, rsp_id=0 after 4 scan cycles; next_id unchanged.
3. slot_enabled=0001, slot_overlap[0]=1 during CHECK, create -> slot_check=0001 for one cycle, REJECT, no slot_update.
4. slot_id[2]=5 with slot 2 enabled, destroy-by-id req_id=5 -> slot_update=0100 with slot_enable=0, OK, rsp_id=5; req_id=9 -> REJECT.
5. ID_WIDTH=2: three successful creates -> third returns rsp_id=3, exhausted=1, violation=1; fourth create -> EXHAUSTED after 1 cycle.
6. Hold rsp_ready=0 for 10 cycles -> rsp_valid, rsp_status and rsp_id stable, req_ready=0. Drop puc_rst_n during SCAN -> all outputs at reset values, next_id=1.
